// File: rtl/tank_renderer_if.sv
// Tank shadow-register update bus.
// The master drives one tank's position, heading and visibility per valid cycle.
interface tank_renderer_if #(
    parameter int COORD_W = 10,
    parameter int TRIG_W  = 8
);
    logic                      upd_valid;
    logic [2:0]                upd_idx;
    logic                      upd_en;
    logic [COORD_W-1:0]        upd_x;
    logic [COORD_W-1:0]        upd_y;
    logic signed [TRIG_W-1:0]  upd_sin;
    logic signed [TRIG_W-1:0]  upd_cos;

    modport master (
        output upd_valid, upd_idx, upd_en, upd_x, upd_y, upd_sin, upd_cos
    );

    modport slave (
        input  upd_valid, upd_idx, upd_en, upd_x, upd_y, upd_sin, upd_cos
    );
endinterface

// File: rtl/tank_renderer.sv
// Pipelined tank sprite compositor between the VGA timing generator and the DAC.
// Each tank is a rotated rectangle; tank state is double-buffered and swapped on
// frame_start. Fixed 3-cycle latency from DrawX/DrawY/blank to RGB/tank_hit.
// Optional feature macro: TANK_BARREL_EN (draws a half-brightness barrel).
module tank_renderer #(
    parameter int NUM_TANKS  = 2,
    parameter int COORD_W    = 10,
    parameter int TRIG_W     = 8,
    parameter int HALF_L     = 12,
    parameter int HALF_W     = 8,
    parameter int BARREL_LEN = 8,
    parameter logic [24*NUM_TANKS-1:0] TANK_COLORS = 48'hFFBB00_FF0000,
    parameter logic [23:0] BG_COLOR = 24'h555555
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    tank_renderer_if.slave       upd,
    input  logic [COORD_W-1:0]   DrawX,
    input  logic [COORD_W-1:0]   DrawY,
    input  logic                 blank,
    output logic [7:0]           Red,
    output logic [7:0]           Green,
    output logic [7:0]           Blue,
    output logic [NUM_TANKS-1:0] tank_hit
);
    localparam int DW = COORD_W + 1;          // signed pixel offset
    localparam int PW = COORD_W + TRIG_W + 1; // full-precision product
    localparam int SW = PW + 1;               // sum of two products

    localparam logic signed [SW-1:0] LIM_L  = SW'(HALF_L);
    localparam logic signed [SW-1:0] LIM_LN = SW'(-HALF_L);
    localparam logic signed [SW-1:0] LIM_W  = SW'(HALF_W);
    localparam logic signed [SW-1:0] LIM_WN = SW'(-HALF_W);
`ifdef TANK_BARREL_EN
    localparam logic signed [SW-1:0] LIM_B  = SW'(HALF_L + BARREL_LEN);
    localparam logic signed [SW-1:0] ONE_P  = SW'(1);
    localparam logic signed [SW-1:0] ONE_N  = SW'(-1);
`endif

    // Shadow and active tank banks
    logic                     sh_en  [NUM_TANKS];
    logic [COORD_W-1:0]       sh_x   [NUM_TANKS];
    logic [COORD_W-1:0]       sh_y   [NUM_TANKS];
    logic signed [TRIG_W-1:0] sh_sin [NUM_TANKS];
    logic signed [TRIG_W-1:0] sh_cos [NUM_TANKS];
    logic                     act_en [NUM_TANKS];
    logic [COORD_W-1:0]       act_x  [NUM_TANKS];
    logic [COORD_W-1:0]       act_y  [NUM_TANKS];
    logic signed [TRIG_W-1:0] act_sin[NUM_TANKS];
    logic signed [TRIG_W-1:0] act_cos[NUM_TANKS];

    // Pipeline stage registers
    logic                     blank1, blank2;
    logic signed [DW-1:0]     dx1 [NUM_TANKS];
    logic signed [DW-1:0]     dy1 [NUM_TANKS];
    logic signed [TRIG_W-1:0] sin1[NUM_TANKS];
    logic signed [TRIG_W-1:0] cos1[NUM_TANKS];
    logic                     en1 [NUM_TANKS];
    logic signed [PW-1:0]     p_xc[NUM_TANKS];
    logic signed [PW-1:0]     p_ys[NUM_TANKS];
    logic signed [PW-1:0]     p_yc[NUM_TANKS];
    logic signed [PW-1:0]     p_xs[NUM_TANKS];
    logic                     en2 [NUM_TANKS];

    // Stage-3 combinational results
    logic signed [SW-1:0]     u_sum, v_sum, u_q, v_q;
    logic                     body_hit;
`ifdef TANK_BARREL_EN
    logic                     barrel_hit;
`endif
    logic [23:0]              cur_col;
    logic [23:0]              col_s3;
    logic [NUM_TANKS-1:0]     hit_s3;
    logic                     found;

    // Bank maintenance: shadow writes, frame-start swap with same-cycle forwarding
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                sh_en[i]   <= 1'b0;
                sh_x[i]    <= '0;
                sh_y[i]    <= '0;
                sh_sin[i]  <= '0;
                sh_cos[i]  <= TRIG_W'(64);
                act_en[i]  <= 1'b0;
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_sin[i] <= '0;
                act_cos[i] <= TRIG_W'(64);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                if (upd.upd_valid && 32'(upd.upd_idx) == i) begin
                    sh_en[i]  <= upd.upd_en;
                    sh_x[i]   <= upd.upd_x;
                    sh_y[i]   <= upd.upd_y;
                    sh_sin[i] <= upd.upd_sin;
                    sh_cos[i] <= upd.upd_cos;
                end
                if (frame_start) begin
                    // A coincident update bypasses the shadow so it lands this frame
                    if (upd.upd_valid && 32'(upd.upd_idx) == i) begin
                        act_en[i]  <= upd.upd_en;
                        act_x[i]   <= upd.upd_x;
                        act_y[i]   <= upd.upd_y;
                        act_sin[i] <= upd.upd_sin;
                        act_cos[i] <= upd.upd_cos;
                    end else begin
                        act_en[i]  <= sh_en[i];
                        act_x[i]   <= sh_x[i];
                        act_y[i]   <= sh_y[i];
                        act_sin[i] <= sh_sin[i];
                        act_cos[i] <= sh_cos[i];
                    end
                end
            end
        end
    end

    // S1: pixel offset from each tank centre; tank state travels with the pixel
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank1 <= 1'b0;
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                dx1[i]  <= '0;
                dy1[i]  <= '0;
                sin1[i] <= '0;
                cos1[i] <= '0;
                en1[i]  <= 1'b0;
            end
        end else begin
            blank1 <= blank;
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                dx1[i]  <= $signed({1'b0, DrawX}) - $signed({1'b0, act_x[i]});
                dy1[i]  <= $signed({1'b0, DrawY}) - $signed({1'b0, act_y[i]});
                sin1[i] <= act_sin[i];
                cos1[i] <= act_cos[i];
                en1[i]  <= act_en[i];
            end
        end
    end

    // S2: full-precision rotation products
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank2 <= 1'b0;
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                p_xc[i] <= '0;
                p_ys[i] <= '0;
                p_yc[i] <= '0;
                p_xs[i] <= '0;
                en2[i]  <= 1'b0;
            end
        end else begin
            blank2 <= blank1;
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                p_xc[i] <= dx1[i] * cos1[i];
                p_ys[i] <= dy1[i] * sin1[i];
                p_yc[i] <= dy1[i] * cos1[i];
                p_xs[i] <= dx1[i] * sin1[i];
                en2[i]  <= en1[i];
            end
        end
    end

    // S3 combinational: body-frame coordinates, coverage and priority colour
    always_comb begin
        col_s3   = BG_COLOR;
        hit_s3   = '0;
        found    = 1'b0;
        u_sum    = '0;
        v_sum    = '0;
        u_q      = '0;
        v_q      = '0;
        body_hit = 1'b0;
        cur_col  = '0;
`ifdef TANK_BARREL_EN
        barrel_hit = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_TANKS; i++) begin
            u_sum    = p_xc[i] + p_ys[i];
            v_sum    = p_yc[i] - p_xs[i];
            u_q      = u_sum >>> 6;
            v_q      = v_sum >>> 6;
            body_hit = en2[i] && (u_q >= LIM_LN) && (u_q <= LIM_L)
                              && (v_q >= LIM_WN) && (v_q <= LIM_W);
            cur_col   = TANK_COLORS[24*i +: 24];
            hit_s3[i] = body_hit;
`ifdef TANK_BARREL_EN
            barrel_hit = en2[i] && (u_q > LIM_L) && (u_q <= LIM_B)
                                && (v_q >= ONE_N) && (v_q <= ONE_P);
            if (barrel_hit) begin
                hit_s3[i] = 1'b1;
                cur_col   = {1'b0, cur_col[23:17], 1'b0, cur_col[15:9], 1'b0, cur_col[7:1]};
            end
`endif
            if (!found && hit_s3[i]) begin
                found  = 1'b1;
                col_s3 = cur_col;
            end
        end
    end

    // S3: registered outputs, forced to zero outside active video
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red      <= '0;
            Green    <= '0;
            Blue     <= '0;
            tank_hit <= '0;
        end else if (blank2) begin
            {Red, Green, Blue} <= col_s3;
            tank_hit           <= hit_s3;
        end else begin
            Red      <= '0;
            Green    <= '0;
            Blue     <= '0;
            tank_hit <= '0;
        end
    end
endmodule
